result_reader: RTL

//  Readback side of the result memory: drains a block of results written by the operation datapath.
//  On start, reads COUNT consecutive words from BASE (wrapping modulo MEM_DEPTH) over a synchronous read port.

---
 rtl/result_mem_pkg.sv | 14 +
 rtl/result_reader_if.sv | 29 ++
 rtl/result_rd_fifo.sv | 54 +++++
 rtl/result_reader.sv | 95 +++++++++
 4 files changed

// File: rtl/result_mem_pkg.sv
// Shared sizing, FSM state type and FIFO payload for the result readback path.
package result_mem_pkg;
  localparam int MEM_WIDTH = 32;
  localparam int MEM_DEPTH = 8;
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int CW        = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rr_state_e;

  typedef struct packed {
    logic                 last;
    logic [MEM_WIDTH-1:0] data;
  } rr_word_t;
endpackage

// File: rtl/result_reader_if.sv
// Request, memory read port and output stream of the result reader.
interface result_reader_if;
  import result_mem_pkg::*;

  logic                 start_i;
  logic [AW-1:0]        base_addr_i;
  logic [CW-1:0]        count_i;
  logic                 mem_rd_en_o;
  logic [AW-1:0]        mem_addr_o;
  logic [MEM_WIDTH-1:0] mem_data_i;
  logic [MEM_WIDTH-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 busy_o;
  logic                 done_o;

  // reader side
  modport master (
    input  start_i, base_addr_i, count_i, mem_data_i, ready_i,
    output mem_rd_en_o, mem_addr_o, data_o, valid_o, last_o, busy_o, done_o
  );

  // requester / memory / stream consumer side
  modport slave (
    output start_i, base_addr_i, count_i, mem_data_i, ready_i,
    input  mem_rd_en_o, mem_addr_o, data_o, valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/result_rd_fifo.sv
// Two-entry FIFO holding {last,data} words between the memory port and the stream.
module result_rd_fifo
  import result_mem_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  rr_word_t wdata_i,
  input  logic     pop_i,
  output rr_word_t rdata_o,
  output logic [1:0] occ_o,
  output logic     full_o,
  output logic     empty_o
);
  rr_word_t   mem_q [2];
  rr_word_t   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;

  // next-state: write at wr_ptr, read at rd_ptr, occupancy tracks push minus pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + 2'(push_i) - 2'(pop_i);
  end

  // storage and pointers; entries cleared so the stream reads 0 out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
endmodule

// File: rtl/result_reader.sv
// Reads COUNT words from BASE (wrapping) and streams them out with last/done.
module result_reader
  import result_mem_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  result_reader_if.master bus
);
  rr_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;

  logic          issue, pop, push;
  logic [1:0]    occ;
  logic          fifo_full, fifo_empty;
  rr_word_t      fifo_wdata, fifo_rdata;

  assign pop  = ~fifo_empty & bus.ready_i;
  assign push = infl_q;

  // Count this cycle's pop as freed space so a continuously ready consumer
  // sees one word per cycle; slot usage never exceeds two entries.
  assign issue = (state_q == READ) && ((occ + 2'(infl_q) - 2'(pop)) < 2'd2);

  // FSM, address/remaining counters and in-flight tracking
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == CW'(1));
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          addr_d  = bus.base_addr_i;
          rem_d   = bus.count_i;
          state_d = (bus.count_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_rdata.last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control registers; reset also drops any read still in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  assign fifo_wdata = '{last: infl_last_q, data: bus.mem_data_i};

  result_rd_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .occ_o   (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.mem_rd_en_o = issue;
  assign bus.mem_addr_o  = addr_q;
  assign bus.valid_o     = ~fifo_empty;
  assign bus.data_o      = fifo_rdata.data;
  assign bus.last_o      = fifo_rdata.last & ~fifo_empty;
  assign bus.busy_o      = (state_q == READ) || (state_q == DRAIN);
  assign bus.done_o      = (state_q == DONE);
endmodule
